// File: rtl/rs_dispatch_ctrl.sv
// rs_dispatch_ctrl: dual-slot dispatch into ALU/LSU/BRU reservation stations with credit and ROB-tail tracking.
module rs_dispatch_ctrl #(
    parameter int NUM_RS_ENTRIES = 16,
    parameter int ROB_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ROB_WIDTH-1:0] flush_rob_id,
    input  logic                 in_valid_0,
    input  logic                 in_valid_1,
    input  logic [1:0]           in_class_0,
    input  logic [1:0]           in_class_1,
    input  logic [ROB_WIDTH:0]   rob_free,
    input  logic [2:0]           issue_valid,
    output logic [2:0]           dispatch_valid_0,
    output logic [2:0]           dispatch_valid_1,
    output logic [ROB_WIDTH-1:0] rob_id_0,
    output logic [ROB_WIDTH-1:0] rob_id_1,
    output logic                 accept_0,
    output logic                 accept_1,
    output logic                 stall_dispatch,
    output logic [31:0]          stall_cycles
);
    localparam int CW = $clog2(NUM_RS_ENTRIES) + 1;
    localparam logic [CW-1:0] FULL = CW'(NUM_RS_ENTRIES);

    logic [CW-1:0]        cred [3];
    logic [CW:0]          cred_sum [3];
    logic [ROB_WIDTH-1:0] rob_tail;
    logic [CW-1:0]        avail_0, avail_1;
    logic                 live;

    // Availability comes from registered credits only; issue pulses land next cycle.
    always_comb begin
        live = !rst && !flush;
        avail_0 = in_class_0 == 2'd0 ? cred[0] : in_class_0 == 2'd1 ? cred[1] : cred[2];
        avail_1 = in_class_1 == 2'd0 ? cred[0] : in_class_1 == 2'd1 ? cred[1] : cred[2];
        accept_0 = live && in_valid_0 && rob_free != '0 &&
                   (in_class_0 == 2'd3 || avail_0 != '0);
        accept_1 = accept_0 && in_valid_1 && rob_free > (ROB_WIDTH+1)'(1) &&
                   (in_class_1 == 2'd3 || int'(avail_1) >= (in_class_1 == in_class_0 ? 2 : 1));
        dispatch_valid_0 = accept_0 && in_class_0 != 2'd3 ? 3'b001 << in_class_0 : 3'b000;
        dispatch_valid_1 = accept_1 && in_class_1 != 2'd3 ? 3'b001 << in_class_1 : 3'b000;
        stall_dispatch = live && ((in_valid_0 && !accept_0) || (in_valid_1 && !accept_1));
        rob_id_0 = rob_tail;
        rob_id_1 = rob_tail + 1'b1;
        for (int k = 0; k < 3; k++)
            cred_sum[k] = {1'b0, cred[k]} + (CW+1)'(issue_valid[k])
                        - (CW+1)'(dispatch_valid_0[k]) - (CW+1)'(dispatch_valid_1[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred         <= '{default: FULL};
            rob_tail     <= '0;
            stall_cycles <= '0;
        end else if (flush) begin
            cred     <= '{default: FULL};
            rob_tail <= flush_rob_id;
        end else begin
            for (int k = 0; k < 3; k++)
                cred[k] <= cred_sum[k][CW-1:0];
            rob_tail <= rob_tail + ROB_WIDTH'(accept_0) + ROB_WIDTH'(accept_1);
            if (stall_dispatch && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Underflow wraps into the top bit of the widened sum, so one bound catches both errors.
    for (genvar k = 0; k < 3; k++) begin : g_chk
        a_cred_range: assert property (@(posedge clk) disable iff (rst)
            !flush |-> cred_sum[k] <= (CW+1)'(NUM_RS_ENTRIES));
    end
endmodule
